// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one word-wide RAM port among NREQ requesters, with optional multi-word lock.
// Build option: define ARB_ERR_RETRY_EN to reissue a word up to MAX_RETRY times after a RAM ERROR.
package ram_port_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_LOCK  = 2,
    parameter int MAX_RETRY = 3,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_ren,
    input  logic [NREQ-1:0]         req_wen,
    input  logic [NREQ-1:0]         req_lock,
    input  word_t [NREQ-1:0]        req_addr,
    input  word_t [NREQ-1:0]        req_store,
    output logic [NREQ-1:0]         req_wait,
    output word_t [NREQ-1:0]        req_load,
    output logic [NREQ-1:0]         req_err,
    output logic                    ramREN,
    output logic                    ramWEN,
    output word_t                   ramaddr,
    output word_t                   ramstore,
    input  word_t                   ramload,
    input  ramstate_t               ramstate,
    output logic                    grant_valid,
    output logic [IDW-1:0]          grant_id
);

    localparam int LOCKW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK + 1) : 1;

`ifdef ARB_ERR_RETRY_EN
    localparam int RETW = $clog2(MAX_RETRY + 1);
    typedef enum logic [1:0] {IDLE, XFER, RETRY} state_t;
    logic [RETW-1:0] retry_cnt;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [LOCKW-1:0] lock_cnt;

    logic [NREQ-1:0]  req;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   next_ptr;
    logic             found;
    logic             active;
    logic             hit;
    logic             err_final;
    logic             done;
    logic             keep_lock;
    logic             release_grant;

    assign req      = req_ren | req_wen;
    assign next_ptr = IDW'((int'(grant_id) + 1) % NREQ);

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        winner = rr_ptr;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // RAM side follows the granted requester combinationally; dropping its request aborts at once.
    always_comb begin
        active    = (state == XFER) && req[grant_id];
        ramWEN    = active && req_wen[grant_id];
        ramREN    = active && req_ren[grant_id] && !req_wen[grant_id];
        ramaddr   = active ? req_addr[grant_id]  : '0;
        ramstore  = active ? req_store[grant_id] : '0;
        hit       = active && (ramstate == ACCESS);
`ifdef ARB_ERR_RETRY_EN
        err_final = active && (ramstate == ERROR) && (retry_cnt == RETW'(MAX_RETRY));
`else
        err_final = active && (ramstate == ERROR);
`endif
        done      = (hit || err_final) && !RST;
        keep_lock = req_lock[grant_id] && (lock_cnt < LOCKW'(MAX_LOCK - 1));
    end

    always_comb begin
        req_wait = '1;
        req_load = '0;
        req_err  = '0;
        if (done) begin
            req_wait[grant_id] = 1'b0;
            req_err[grant_id]  = err_final;
            req_load[grant_id] = (hit && !req_wen[grant_id]) ? ramload : '0;
        end
    end

    // Grant ends on abort, on an unlocked or exhausted-lock completion, or on a final error.
    always_comb begin
        release_grant = 1'b0;
        case (state)
            XFER:    release_grant = !req[grant_id] || (hit && !keep_lock) || err_final;
`ifdef ARB_ERR_RETRY_EN
            RETRY:   release_grant = !req[grant_id];
`endif
            default: release_grant = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            lock_cnt    <= '0;
`ifdef ARB_ERR_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else if (release_grant) begin
            // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
            state       <= IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        lock_cnt    <= '0;
`ifdef ARB_ERR_RETRY_EN
                        retry_cnt   <= '0;
`endif
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if (hit) begin
                        lock_cnt  <= lock_cnt + 1'b1;
`ifdef ARB_ERR_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
`ifdef ARB_ERR_RETRY_EN
                    else if (active && ramstate == ERROR) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= RETRY;
                    end
                    else begin
                        state <= XFER;
                    end
                end
                RETRY: begin
                    state <= XFER;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
